stage4_defast_message_mux_ctrl: RTL and testbench

- Sequencer for the stage-4 FAST-decode message mux. It drives the three lane select codes `message_mux_control_m1/m2/m3` so each lane emits a programmed field sequence drawn from a/d/k/q/N.
- Per-lane field templates are written into small code tables by the stage-4 configuration path.
- One message is a walk of all three tables in lock-step, one step per accepted cycle, under a valid/ready handshake with downstream.

---
 rtl/stage4_defast_message_mux_ctrl_pkg.sv | 27 ++
 rtl/stage4_defast_message_mux_ctrl_if.sv | 38 +++
 rtl/stage4_defast_tmpl_table.sv | 23 ++
 rtl/stage4_defast_message_mux_ctrl.sv | 109 ++++++++++
 tb/tb_stage4_defast_message_mux_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage4_defast_message_mux_ctrl_pkg.sv
// rtl/stage4_defast_message_mux_ctrl_pkg.sv - shared constants, codes and FSM encodings for the stage-4 mux sequencer
package stage4_defast_message_mux_ctrl_pkg;

  localparam int TMPL_DEPTH = 8;
  localparam int STEP_W     = $clog2(TMPL_DEPTH);
  localparam int LEN_W      = 4;
  localparam int CTRL_W     = 3;

  typedef logic [CTRL_W-1:0] mux_code_t;

  localparam mux_code_t MESSAGE_MUX_A    = 3'd0;
  localparam mux_code_t MESSAGE_MUX_D    = 3'd1;
  localparam mux_code_t MESSAGE_MUX_K    = 3'd2;
  localparam mux_code_t MESSAGE_MUX_Q    = 3'd3;
  localparam mux_code_t MESSAGE_MUX_N    = 3'd4;
  // Unused code: the message mux falls through to its default message.
  localparam mux_code_t MESSAGE_MUX_NONE = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(TMPL_DEPTH)) ? LEN_W'(TMPL_DEPTH) : len;
  endfunction

endpackage

// File: rtl/stage4_defast_message_mux_ctrl_if.sv
// rtl/stage4_defast_message_mux_ctrl_if.sv - config, handshake and select bundle of the stage-4 mux sequencer
interface stage4_defast_message_mux_ctrl_if;
  import stage4_defast_message_mux_ctrl_pkg::*;

  logic              tmpl_wr_en;
  logic [1:0]        tmpl_wr_lane;
  logic [STEP_W-1:0] tmpl_wr_addr;
  mux_code_t         tmpl_wr_code;
  logic [LEN_W-1:0]  tmpl_len_1;
  logic [LEN_W-1:0]  tmpl_len_2;
  logic [LEN_W-1:0]  tmpl_len_3;
  logic              msg_start;
  logic              msg_abort;
  logic              ctrl_ready;
  mux_code_t         message_mux_control_m1;
  mux_code_t         message_mux_control_m2;
  mux_code_t         message_mux_control_m3;
  logic              ctrl_valid;
  logic [STEP_W-1:0] ctrl_step;
  logic              busy;
  logic              msg_done;
  logic              cfg_err;

  modport master (
    output tmpl_wr_en, tmpl_wr_lane, tmpl_wr_addr, tmpl_wr_code,
    output tmpl_len_1, tmpl_len_2, tmpl_len_3, msg_start, msg_abort, ctrl_ready,
    input  message_mux_control_m1, message_mux_control_m2, message_mux_control_m3,
    input  ctrl_valid, ctrl_step, busy, msg_done, cfg_err
  );

  modport slave (
    input  tmpl_wr_en, tmpl_wr_lane, tmpl_wr_addr, tmpl_wr_code,
    input  tmpl_len_1, tmpl_len_2, tmpl_len_3, msg_start, msg_abort, ctrl_ready,
    output message_mux_control_m1, message_mux_control_m2, message_mux_control_m3,
    output ctrl_valid, ctrl_step, busy, msg_done, cfg_err
  );

endinterface

// File: rtl/stage4_defast_tmpl_table.sv
// rtl/stage4_defast_tmpl_table.sv - one-lane field template register file, 1 write / 1 async read
module stage4_defast_tmpl_table
  import stage4_defast_message_mux_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  mux_code_t         wr_code,
  input  logic [STEP_W-1:0] rd_addr,
  output mux_code_t         rd_code
);

  mux_code_t mem [TMPL_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_code;
    end
  end

  assign rd_code = mem[rd_addr];

endmodule

// File: rtl/stage4_defast_message_mux_ctrl.sv
// rtl/stage4_defast_message_mux_ctrl.sv - sequences the three stage-4 lane select codes through programmed templates
module stage4_defast_message_mux_ctrl
  import stage4_defast_message_mux_ctrl_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  stage4_defast_message_mux_ctrl_if.slave bus
);

  logic [1:0]                  state;
  logic [STEP_W-1:0]           step;
  logic [2:0][LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]            len_max_q;
  logic                        cfg_err_q;
  logic                        idle;
  logic [2:0][LEN_W-1:0]       len_in;
  logic [LEN_W-1:0]            len_in_max;
  logic [2:0]                  lane_we;
  logic [2:0][CTRL_W-1:0]      rd_code;
  logic [2:0][CTRL_W-1:0]      sel;

  assign idle      = (state == ST_IDLE);
  assign len_in[0] = clamp_len(bus.tmpl_len_1);
  assign len_in[1] = clamp_len(bus.tmpl_len_2);
  assign len_in[2] = clamp_len(bus.tmpl_len_3);

  always_comb begin
    len_in_max = len_in[0];
    if (len_in[1] > len_in_max) len_in_max = len_in[1];
    if (len_in[2] > len_in_max) len_in_max = len_in[2];
  end

  // Tables are frozen while a message is in flight so every step reads a stable template.
  for (genvar i = 0; i < 3; i++) begin : g_lane
    assign lane_we[i] = bus.tmpl_wr_en && idle && (bus.tmpl_wr_lane == 2'(i + 1));

    stage4_defast_tmpl_table u_tbl (
      .clk     (clk),
      .wr_en   (lane_we[i]),
      .wr_addr (bus.tmpl_wr_addr),
      .wr_code (bus.tmpl_wr_code),
      .rd_addr (step),
      .rd_code (rd_code[i])
    );

    assign sel[i] = ((state == ST_RUN) && (LEN_W'(step) < len_q[i])) ? rd_code[i] : MESSAGE_MUX_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      step      <= '0;
      len_q     <= '0;
      len_max_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.tmpl_wr_en && (bus.tmpl_wr_lane == 2'd0)) cfg_err_q <= 1'b1;
          if (bus.msg_start) begin
            if (len_in_max != '0) begin
              len_q     <= len_in;
              len_max_q <= len_in_max;
              step      <= '0;
              state     <= ST_RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.tmpl_wr_en) cfg_err_q <= 1'b1;
          // Abort wins over a same-cycle accept.
          if (bus.msg_abort) begin
            state <= ST_IDLE;
            step  <= '0;
          end else if (bus.ctrl_ready) begin
            if (LEN_W'(step) == len_max_q - LEN_W'(1)) begin
              state <= ST_DONE;
              step  <= '0;
            end else begin
              step <= step + STEP_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.tmpl_wr_en) cfg_err_q <= 1'b1;
          state <= ST_IDLE;
          step  <= '0;
        end
        default: begin
          state <= ST_IDLE;
          step  <= '0;
        end
      endcase
    end
  end

  assign bus.message_mux_control_m1 = sel[0];
  assign bus.message_mux_control_m2 = sel[1];
  assign bus.message_mux_control_m3 = sel[2];
  assign bus.ctrl_valid             = (state == ST_RUN);
  assign bus.ctrl_step              = step;
  assign bus.busy                   = !idle;
  assign bus.msg_done               = (state == ST_DONE);
  assign bus.cfg_err                = cfg_err_q;

endmodule

// File: tb/tb_stage4_defast_message_mux_ctrl.sv
// tb/tb_stage4_defast_message_mux_ctrl.sv - randomized self-checking bench for the stage-4 mux sequencer
module tb_stage4_defast_message_mux_ctrl;
  import stage4_defast_message_mux_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stage4_defast_message_mux_ctrl_if bus ();

  stage4_defast_message_mux_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux_code_t tbl [1:3][0:7];
  int        mlen [1:3];
  int        n_cmp = 0;
  int        n_err = 0;

  function automatic logic [14:0] obs();
    return {bus.ctrl_valid, bus.busy, bus.msg_done, bus.ctrl_step,
            bus.message_mux_control_m1, bus.message_mux_control_m2, bus.message_mux_control_m3};
  endfunction

  function automatic logic [14:0] exp_idle();
    return {3'b000, 3'd0, MESSAGE_MUX_NONE, MESSAGE_MUX_NONE, MESSAGE_MUX_NONE};
  endfunction

  function automatic logic [14:0] exp_done();
    return {3'b011, 3'd0, MESSAGE_MUX_NONE, MESSAGE_MUX_NONE, MESSAGE_MUX_NONE};
  endfunction

  function automatic logic [14:0] exp_run(input int s);
    mux_code_t c [1:3];
    for (int l = 1; l <= 3; l++) c[l] = (s < mlen[l]) ? tbl[l][s] : MESSAGE_MUX_NONE;
    return {3'b110, 3'(s), c[1], c[2], c[3]};
  endfunction

  function automatic int model_clamp(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.tmpl_wr_en   = 1'b0;
    bus.tmpl_wr_lane = 2'd0;
    bus.tmpl_wr_addr = 3'd0;
    bus.tmpl_wr_code = MESSAGE_MUX_NONE;
    bus.msg_start    = 1'b0;
    bus.msg_abort    = 1'b0;
    bus.ctrl_ready   = 1'b0;
  endtask

  task automatic set_lens(input int l1, input int l2, input int l3);
    bus.tmpl_len_1 = 4'(l1);
    bus.tmpl_len_2 = 4'(l2);
    bus.tmpl_len_3 = 4'(l3);
  endtask

  task automatic tb_write(input int lane, input int addr, input mux_code_t code);
    bus.tmpl_wr_en   = 1'b1;
    bus.tmpl_wr_lane = 2'(lane);
    bus.tmpl_wr_addr = 3'(addr);
    bus.tmpl_wr_code = code;
    tick();
    bus.tmpl_wr_en = 1'b0;
    if (lane != 0) tbl[lane][addr] = code;
    n_cmp++;
    if (bus.cfg_err !== (lane == 0)) begin
      n_err++;
      $display("FAIL idle_write_cfg_err lane=%0d got=%b exp=%b", lane, bus.cfg_err, (lane == 0));
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: three stall cycles on step 1
  task automatic run_msg(input int mode);
    int lm, s, cyc, stall;
    bit r;
    mlen[1] = model_clamp(int'(bus.tmpl_len_1));
    mlen[2] = model_clamp(int'(bus.tmpl_len_2));
    mlen[3] = model_clamp(int'(bus.tmpl_len_3));
    lm = mlen[1];
    if (mlen[2] > lm) lm = mlen[2];
    if (mlen[3] > lm) lm = mlen[3];
    bus.msg_start = 1'b1;
    tick();
    bus.msg_start = 1'b0;
    s = 0; cyc = 0; stall = 0;
    while (s < lm && cyc < 200) begin
      n_cmp++;
      if (obs() !== exp_run(s)) begin
        n_err++;
        $display("FAIL run_step mode=%0d s=%0d got=%h exp=%h", mode, s, obs(), exp_run(s));
      end
      n_cmp++;
      if (bus.cfg_err !== 1'b0) begin
        n_err++;
        $display("FAIL run_cfg_err s=%0d got=%b exp=0", s, bus.cfg_err);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: begin
          r = !(s == 1 && stall < 3);
          if (!r) stall++;
        end
      endcase
      bus.ctrl_ready = r;
      tick();
      cyc++;
      if (r) s++;
    end
    bus.ctrl_ready = 1'b0;
    n_cmp++;
    if (cyc >= 200) begin
      n_err++;
      $display("FAIL run_timeout got=%0d cycles exp<200", cyc);
    end
    n_cmp++;
    if (obs() !== exp_done()) begin
      n_err++;
      $display("FAIL done_state got=%h exp=%h", obs(), exp_done());
    end
    tick();
    n_cmp++;
    if (obs() !== exp_idle()) begin
      n_err++;
      $display("FAIL after_done got=%h exp=%h", obs(), exp_idle());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    set_lens(0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({obs(), bus.cfg_err} !== {exp_idle(), 1'b0}) begin
      n_err++;
      $display("FAIL reset_state got=%h exp=%h", {obs(), bus.cfg_err}, {exp_idle(), 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++;
    if (obs() !== exp_idle()) begin
      n_err++;
      $display("FAIL post_reset got=%h exp=%h", obs(), exp_idle());
    end
  endtask

  task automatic test_basic();
    for (int l = 1; l <= 3; l++)
      for (int a = 0; a < 8; a++) tb_write(l, a, 3'($urandom_range(0, 7)));
    tb_write(1, 0, MESSAGE_MUX_A);
    tb_write(1, 1, MESSAGE_MUX_D);
    tb_write(1, 2, MESSAGE_MUX_K);
    tb_write(2, 0, MESSAGE_MUX_Q);
    tb_write(2, 1, MESSAGE_MUX_N);
    tb_write(3, 0, MESSAGE_MUX_N);
    set_lens(3, 2, 1);
    run_msg(0);
  endtask

  task automatic test_stall();
    set_lens(3, 2, 1);
    run_msg(2);
  endtask

  task automatic test_zero_len();
    set_lens(0, 0, 0);
    bus.msg_start = 1'b1;
    tick();
    bus.msg_start = 1'b0;
    n_cmp++;
    if ({obs(), bus.cfg_err} !== {exp_idle(), 1'b1}) begin
      n_err++;
      $display("FAIL zero_len_start got=%h exp=%h", {obs(), bus.cfg_err}, {exp_idle(), 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({obs(), bus.cfg_err} !== {exp_idle(), 1'b0}) begin
        n_err++;
        $display("FAIL zero_len_after i=%0d got=%h exp=%h", i, {obs(), bus.cfg_err}, {exp_idle(), 1'b0});
      end
    end
  endtask

  task automatic test_clamp();
    set_lens(15, $urandom_range(0, 8), $urandom_range(0, 15));
    run_msg(1);
  endtask

  task automatic test_abort();
    set_lens(3, 2, 1);
    mlen[1] = 3; mlen[2] = 2; mlen[3] = 1;
    bus.msg_start = 1'b1;
    tick();
    bus.msg_start  = 1'b0;
    bus.ctrl_ready = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== exp_run(1)) begin
      n_err++;
      $display("FAIL abort_pre got=%h exp=%h", obs(), exp_run(1));
    end
    bus.msg_abort = 1'b1;
    tick();
    bus.msg_abort  = 1'b0;
    bus.ctrl_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs() !== exp_idle()) begin
        n_err++;
        $display("FAIL abort_idle i=%0d got=%h exp=%h", i, obs(), exp_idle());
      end
      tick();
    end
    run_msg(0);
  endtask

  task automatic test_write_busy();
    set_lens(3, 2, 1);
    mlen[1] = 3; mlen[2] = 2; mlen[3] = 1;
    bus.msg_start = 1'b1;
    tick();
    bus.msg_start    = 1'b0;
    bus.tmpl_wr_en   = 1'b1;
    bus.tmpl_wr_lane = 2'd1;
    bus.tmpl_wr_addr = 3'd0;
    bus.tmpl_wr_code = ~tbl[1][0];
    tick();
    bus.tmpl_wr_en = 1'b0;
    n_cmp++;
    if ({obs(), bus.cfg_err} !== {exp_run(0), 1'b1}) begin
      n_err++;
      $display("FAIL busy_write got=%h exp=%h", {obs(), bus.cfg_err}, {exp_run(0), 1'b1});
    end
    bus.msg_abort = 1'b1;
    tick();
    bus.msg_abort = 1'b0;
    tb_write(0, 2, MESSAGE_MUX_Q);
    run_msg(0);
  endtask

  task automatic test_reset_mid();
    set_lens(3, 2, 1);
    mlen[1] = 3; mlen[2] = 2; mlen[3] = 1;
    bus.msg_start = 1'b1;
    tick();
    bus.msg_start  = 1'b0;
    bus.ctrl_ready = 1'b1;
    tick();
    tick();
    bus.ctrl_ready = 1'b0;
    n_cmp++;
    if (obs() !== exp_run(2)) begin
      n_err++;
      $display("FAIL reset_mid_pre got=%h exp=%h", obs(), exp_run(2));
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({obs(), bus.cfg_err} !== {exp_idle(), 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_async got=%h exp=%h", {obs(), bus.cfg_err}, {exp_idle(), 1'b0});
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_msg(0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 4; w++)
        tb_write($urandom_range(1, 3), $urandom_range(0, 7), 3'($urandom_range(0, 7)));
      set_lens($urandom_range(1, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      run_msg(1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_clamp();
    test_abort();
    test_write_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
